// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants, receiver state encoding and vote helper
package uart_pkg;

    localparam int UART_OVERSAMPLE = 16;
    localparam int UART_DATA_BITS  = 8;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } uart_rx_state_e;

    // 2-of-3 majority of three line samples
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - two-flop synchronizer with configurable reset value
module uart_rx_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver; UART_RX_MAJORITY_EN enables 2-of-3 vote sampling
module uart_rx
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_done,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    uart_rx_state_e       state;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 rx_s;
    logic                 sample;

    uart_rx_sync #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

`ifdef UART_RX_MAJORITY_EN
    logic [1:0] vote_hist;

    // Keep the line values of the two previous ticks for the vote
    always_ff @(posedge clk) begin
        if (rst) begin
            vote_hist <= 2'b11;
        end else if (tick) begin
            vote_hist <= {vote_hist[0], rx_s};
        end
    end

    assign sample = maj3(vote_hist[1], vote_hist[0], rx_s);
`else
    assign sample = rx_s;
`endif

    // Frame FSM: start detect, mid-bit sampling, stop check and break hold-off
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            if (tick) begin
                unique case (state)
                    ST_IDLE: begin
                        if (!rx_s) begin
                            tick_cnt <= '0;
                            state    <= ST_START;
                            busy     <= 1'b1;
                        end
                    end
                    ST_START: begin
                        if (tick_cnt == TICK_MID) begin
                            if (!sample) begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= ST_DATA;
                            end else begin
                                state <= ST_IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (tick_cnt == TICK_END) begin
                            shreg    <= {sample, shreg[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (bit_cnt == BIT_LAST) begin
                                state <= ST_STOP;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_STOP: begin
                        if (tick_cnt == TICK_END) begin
                            tick_cnt <= '0;
                            if (sample) begin
                                rx_data <= shreg;
                                rx_done <= 1'b1;
                                state   <= ST_IDLE;
                                busy    <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= ST_WAIT_IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                    ST_WAIT_IDLE: begin
                        if (rx_s) begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that recovers 8N1 serial frames from the asynchronous `rx` line, using the oversampling `tick` pulse from the baud generator. It sits on the receive side of the UART_TX_RX design, opposite the transmitter, and shares its baud tick source. Each good byte is delivered as parallel data with a one-cycle `rx_done` strobe. Frames with a bad stop bit are flagged with `frame_err`.

## Interface
- `OVERSAMPLE`, 16: number of `tick` pulses per bit period; must be even and ≥ 4.
- `DATA_BITS`, 8: number of data bits per frame, sent LSB first.
- `clk` input 1: system clock.
- `rst` input 1: synchronous, active-high reset.
- `tick` input 1: oversample strobe, one `clk` cycle wide, at `OVERSAMPLE` × baud.
- `rx` input 1: asynchronous serial line; idles high.
- `rx_data` output `DATA_BITS`: last correctly received byte.
- `rx_done` output 1: one-cycle pulse; `rx_data` is valid and updated in that cycle.
- `frame_err` output 1: one-cycle pulse when the stop bit is sampled low.
- `busy` output 1: high in every state except IDLE.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer, giving `rx_s`. The synchronizer flops reset to 1.
- Counters:
  - `tick_cnt`, width `$clog2(OVERSAMPLE)`, counts ticks within the current bit.
  - `bit_cnt`, width `$clog2(DATA_BITS)`, counts data bits.
  - Both advance only on `tick`=1.
- States: IDLE, START, DATA, STOP, WAIT_IDLE.
  - **IDLE:** on any `tick` with `rx_s`=0, clear `tick_cnt` and go to START.
  - **START:** on the tick where `tick_cnt`=`OVERSAMPLE/2-1`, sample the line.
    - Sample 0: clear `tick_cnt` and `bit_cnt`, go to DATA.
    - Sample 1: treat as a glitch and return to IDLE with no output activity.
  - **DATA:** on the tick where `tick_cnt`=`OVERSAMPLE-1`, sample into the shift register, MSB-in with right shift, then clear `tick_cnt`.
    - After the sample with `bit_cnt`=`DATA_BITS-1`, go to STOP.
    - Otherwise increment `bit_cnt`.
  - **STOP:** on the tick where `tick_cnt`=`OVERSAMPLE-1`, sample the line.
    - Sample 1: load `rx_data` from the shift register, pulse `rx_done`, go to IDLE.
    - Sample 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
  - **WAIT_IDLE:** on any tick with `rx_s`=1, go to IDLE. This prevents a held-low line (break) from being decoded as repeated frames.
- If `tick` never arrives, the FSM holds its state indefinitely. There is no timeout.
- `rx_done` and `frame_err` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `rx_data`=0, `rx_done`=0, `frame_err`=0, `busy`=0, both counters 0.
- A reset mid-frame abandons the frame immediately, with no strobe produced.
- Synchronizer latency: 2 `clk` cycles from `rx` to `rx_s`.
- Strobe timing: `rx_done` or `frame_err` is registered, so it goes high in the cycle after the `clk` edge that sampled the stop bit, and stays high for exactly 1 cycle.
- Each data sample falls `OVERSAMPLE/2` ticks (±1 tick of detect jitter) after its nominal bit edge, i.e. at mid-bit.
- Frame length: ≈ `(DATA_BITS+1.5)·OVERSAMPLE` ticks from the start edge to the stop sample. Back-to-back frames are accepted without an idle gap beyond the half stop bit.

## Configuration
- `UART_RX_MAJORITY_EN` defined: each START, DATA and STOP decision is a 2-of-3 majority vote. The votes are `rx_s` at ticks `k-2`, `k-1` and `k`, where `k` is the decision tick. This needs `OVERSAMPLE` ≥ 8.
- `UART_RX_MAJORITY_EN` undefined: a single sample of `rx_s` at the decision tick. No vote registers are built.

## Structure
- Shared package `uart_pkg`:
  - FSM state encoding: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
  - Default constants `UART_OVERSAMPLE`=16 and `UART_DATA_BITS`=8, shared with the transmitter and baud tick divider.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer, parameterised on its reset value (1).

## Test plan
- **Good frame, `OVERSAMPLE`=16:** send 0x55 followed by 0xA3 back-to-back → `rx_data`=0x55 with one `rx_done`, then `rx_data`=0xA3 with one `rx_done`; `frame_err` stays 0.
- **Start-bit glitch:** hold `rx` low for 4 ticks, then high → FSM returns to IDLE; no `rx_done`, no `frame_err`; `busy` falls after the START sample.
- **Framing error:** send 0x3C with the stop bit at 0, then hold `rx` low for 40 ticks → one `frame_err` pulse; `rx_data` keeps its previous value; no new frame starts until `rx` rises. A following 0x7E frame is then received correctly.
- **Reset mid-frame:** assert `rst` for 1 cycle after the 4th data bit → the next cycle shows state=IDLE and all outputs 0. A later 0x81 frame is received correctly.
- **Tick stall:** stop `tick` for 500 `clk` cycles mid-DATA, then resume → 0xC6 is still received correctly; `busy` stays high throughout the stall.
- **Majority vote (`UART_RX_MAJORITY_EN`):** send 0xF0 with a 1-tick inverted pulse on bit 2's decision tick → `rx_data`=0xF0. With the macro undefined, the same stimulus yields 0xF4.
